// File: rtl/imem_uart_loader_if.sv
// Bundle between the UART byte source / button and the IMEM loader.
// The loader owns the IMEM write port and status outputs (master side);
// the byte source and start button sit on the slave side.
interface imem_uart_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  start;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;
  logic [15:0]           words_loaded;

  modport master (
    input  start, rx_data, rx_valid,
    output imem_we, imem_addr, imem_wdata, cpu_hold, done, error, words_loaded
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, done, error, words_loaded
  );
endinterface

// File: rtl/imem_uart_loader.sv
// UART program loader: takes a little-endian word count followed by the
// little-endian words of the image and writes them into IMEM, holding the
// CPU in reset while a load is in progress or after a failed load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start; CPU running
// S_HDR_LO | waiting for low byte of word count
// S_HDR_HI | waiting for high byte of word count, then range check
// S_DATA   | assembling bytes into words and writing IMEM
// S_DONE   | load finished; CPU released one cycle after entry
// S_ERR    | load aborted (timeout or oversize count); CPU held
module imem_uart_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int TCNT_WIDTH     = 24
) (
  input  logic                clk,
  input  logic                rst,
  imem_uart_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  // Counts above the IMEM capacity are rejected, so addresses never wrap.
  localparam logic [16:0]           CAP   = 17'(2 ** ADDR_WIDTH);
  localparam logic [TCNT_WIDTH-1:0] TLAST = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [15:0]           cnt;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [23:0]           wbuf;
  logic [TCNT_WIDTH-1:0] timer;

  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  hold_r;
  logic                  done_r;
  logic                  err_r;
  logic [15:0]           wl_r;

  logic [15:0]           cnt_full;
  logic [15:0]           wl_next;
  logic                  timed_out;

  assign cnt_full  = {bus.rx_data, cnt[7:0]};
  assign wl_next   = wl_r + 16'd1;
  assign timed_out = (timer == TLAST);

  assign bus.imem_we      = we_r;
  assign bus.imem_addr    = addr_r;
  assign bus.imem_wdata   = wdata_r;
  assign bus.cpu_hold     = hold_r;
  assign bus.done         = done_r;
  assign bus.error        = err_r;
  assign bus.words_loaded = wl_r;

  // Load sequencer: header parse, word assembly, IMEM write pulses, timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      byte_idx  <= '0;
      word_addr <= '0;
      wbuf      <= '0;
      timer     <= '0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      hold_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      wl_r      <= '0;
    end else begin
      we_r <= 1'b0;
      if (bus.start) begin
        // Restart wins over a byte arriving in the same cycle; that byte is dropped.
        state     <= S_HDR_LO;
        cnt       <= '0;
        byte_idx  <= '0;
        word_addr <= '0;
        wbuf      <= '0;
        timer     <= '0;
        wl_r      <= '0;
        done_r    <= 1'b0;
        err_r     <= 1'b0;
        hold_r    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            hold_r <= 1'b0;
          end

          S_HDR_LO: begin
            if (bus.rx_valid) begin
              cnt[7:0] <= bus.rx_data;
              timer    <= '0;
              state    <= S_HDR_HI;
            end else if (timed_out) begin
              state <= S_ERR;
              err_r <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_HDR_HI: begin
            if (bus.rx_valid) begin
              cnt[15:8] <= bus.rx_data;
              timer     <= '0;
              if (cnt_full == 16'd0) begin
                state  <= S_DONE;
                done_r <= 1'b1;
              end else if ({1'b0, cnt_full} > CAP) begin
                state <= S_ERR;
                err_r <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end else if (timed_out) begin
              state <= S_ERR;
              err_r <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_DATA: begin
            if (bus.rx_valid) begin
              timer    <= '0;
              byte_idx <= byte_idx + 2'd1;
              case (byte_idx)
                2'd0: wbuf[7:0]   <= bus.rx_data;
                2'd1: wbuf[15:8]  <= bus.rx_data;
                2'd2: wbuf[23:16] <= bus.rx_data;
                default: begin
                  we_r      <= 1'b1;
                  addr_r    <= word_addr;
                  wdata_r   <= {bus.rx_data, wbuf};
                  word_addr <= word_addr + 1'b1;
                  wl_r      <= wl_next;
                  if (wl_next == cnt) begin
                    state  <= S_DONE;
                    done_r <= 1'b1;
                  end
                end
              endcase
            end else if (timed_out) begin
              // Any partially assembled word is simply abandoned.
              state <= S_ERR;
              err_r <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_DONE: begin
            // Released one cycle after entry so the final IMEM write lands first.
            hold_r <= 1'b0;
          end

          S_ERR: begin
            hold_r <= 1'b1;
          end

          default: begin
            state  <= S_IDLE;
            hold_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed + randomized bench for imem_uart_loader (small IMEM, short timeout).
module tb_imem_uart_loader;
  localparam int AW  = 4;
  localparam int TO  = 100;
  localparam int TW  = 8;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic rst;

  imem_uart_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_uart_loader #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO),
    .TCNT_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observed IMEM writes as {addr, data}.
  logic [AW+31:0] obs_q[$];

  always @(posedge clk) begin
    #1;
    if (bus.imem_we === 1'b1) obs_q.push_back({bus.imem_addr, bus.imem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; strobes one byte then idles gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic int pick_gap(input int gmin, input int gmax);
    return int'($urandom_range(gmax, gmin));
  endfunction

  // Full load from start to end of frame, checked against a queue model.
  task automatic run_load(input logic [15:0] cnt, input int gmin, input int gmax, input bit dirty);
    logic [31:0] words[$];
    logic [31:0] w;
    bit ok_cnt;
    bit exp_err;
    int nexp;
    bus.start = 1'b1;
    if (dirty) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h5A;
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    obs_q.delete();
    check("hold_after_start", bus.cpu_hold, 1);
    check("wl_after_start", bus.words_loaded, 0);
    check("flags_after_start", {bus.done, bus.error}, 0);
    send_byte(cnt[7:0], pick_gap(gmin, gmax));
    send_byte(cnt[15:8], pick_gap(gmin, gmax));
    ok_cnt  = (cnt != 16'd0) && (int'(cnt) <= CAP);
    exp_err = (int'(cnt) > CAP);
    if (ok_cnt) begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = $urandom;
        words.push_back(w);
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], pick_gap(gmin, gmax));
      end
    end
    repeat (3) @(negedge clk);
    nexp = ok_cnt ? int'(cnt) : 0;
    check("write_count", obs_q.size(), nexp);
    for (int i = 0; i < nexp && i < obs_q.size(); i++)
      check("write_addr_data", obs_q[i], {AW'(i), words[i]});
    check("done", bus.done, !exp_err);
    check("error", bus.error, exp_err);
    check("cpu_hold", bus.cpu_hold, exp_err);
    check("words_loaded", bus.words_loaded, exp_err ? 0 : int'(cnt));
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_outputs", {bus.imem_we, bus.cpu_hold, bus.done, bus.error}, 0);
    check("rst_wl", bus.words_loaded, 0);
    check("rst_addr_data", {bus.imem_addr, bus.imem_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Known two-instruction image.
    pulse_start();
    obs_q.delete();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h05, 0); send_byte(8'h20, 0); send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    check("img_writes", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("img_w0", obs_q[0], {AW'(0), 32'h00100513});
      check("img_w1", obs_q[1], {AW'(1), 32'h00200593});
    end
    check("img_done", {bus.done, bus.error, bus.cpu_hold}, 3'b100);
    check("img_wl", bus.words_loaded, 2);

    // Header boundaries: empty, full capacity, one over, maximum count.
    run_load(16'd0, 0, 3, 0);
    run_load(16'(CAP), 0, 2, 0);
    run_load(16'(CAP + 1), 0, 3, 0);
    run_load(16'hFFFF, 0, 0, 0);

    // Timeout: error exactly TO cycles after the last accepted byte.
    pulse_start();
    obs_q.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    repeat (TO - 1) @(negedge clk);
    check("to_not_yet", bus.error, 0);
    @(negedge clk);
    check("to_error", bus.error, 1);
    check("to_hold", bus.cpu_hold, 1);
    check("to_no_write", obs_q.size(), 0);
    repeat (2) @(negedge clk);
    check("err_ignores_rx", bus.error, 1);

    // Recovery, then idle gaps just below the timeout, then random loads.
    run_load(16'd2, 0, 4, 0);
    run_load(16'd1, TO - 1, TO - 1, 0);
    for (int k = 0; k < 6; k++) run_load(16'($urandom_range(CAP, 1)), 0, 12, 0);

    // Back-to-back bytes with restart in the middle of word 2.
    pulse_start();
    obs_q.delete();
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    for (int j = 0; j < 4; j++) send_byte(w0[8*j +: 8], 0);
    for (int j = 0; j < 4; j++) send_byte(w1[8*j +: 8], 0);
    send_byte(w2[7:0], 0); send_byte(w2[15:8], 0);
    check("b2b_partial_writes", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("b2b_w0", obs_q[0], {AW'(0), w0});
      check("b2b_w1", obs_q[1], {AW'(1), w1});
    end
    check("b2b_partial_wl", bus.words_loaded, 2);
    run_load(16'd3, 0, 0, 1);

    // Asynchronous reset while an IMEM write pulse is high.
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    bus.rx_data  = 8'h44;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    check("arst_we_high", {bus.imem_we, bus.imem_wdata}, {1'b1, 32'h44332211});
    rst = 1'b1;
    #1;
    check("arst_outputs", {bus.imem_we, bus.cpu_hold, bus.done, bus.error}, 0);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int j = 0; j < 4; j++) send_byte(8'(j + 1), 0);
    repeat (2) @(negedge clk);
    check("idle_no_write", obs_q.size(), 0);
    check("idle_state", {bus.cpu_hold, bus.done, bus.error}, 0);
    check("idle_wl", bus.words_loaded, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
